avmm2axi4lite_bridge: RTL and testbench

- Avalon-MM slave to AXI4-Lite master bridge; the inverse path of the AXI4-Lite-to-AVMM bridge in the packet client.
- Lets AVMM-native initiators (e.g. a JTAG master or sequencer) reach AXI4-Lite CSR targets in the Ethernet subsystem.
- One outstanding transaction at a time, single-beat only.
- Optional response timeout so an unresponsive target cannot stall the AVMM side without an error.

---
 rtl/avmm_axi_bridge_pkg.sv | 18 +
 rtl/avmm2axi4lite_bridge.sv | 171 +++++++++++++++++
 tb/tb_avmm2axi4lite_bridge.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_axi_bridge_pkg.sv
// avmm_axi_bridge_pkg: shared state type and AXI constants for the AVMM-to-AXI4-Lite bridge
package avmm_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DRAIN
    } state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/avmm2axi4lite_bridge.sv
// avmm2axi4lite_bridge: Avalon-MM slave to AXI4-Lite master, one single-beat transaction in flight
module avmm2axi4lite_bridge
    import avmm_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [ADDR_WIDTH-1:0]     avs_address,
    input  logic                      avs_read,
    input  logic                      avs_write,
    input  logic [DATA_WIDTH-1:0]     avs_writedata,
    input  logic [DATA_WIDTH/8-1:0]   avs_byteenable,
    input  logic                      avs_burstcount,
    output logic                      avs_waitrequest,
    output logic [DATA_WIDTH-1:0]     avs_readdata,
    output logic                      avs_readdatavalid,
    output logic                      avs_writeresponsevalid,
    output logic [1:0]                avs_response,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [2:0]                axi_awprot,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    output logic [2:0]                axi_arprot,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [DATA_WIDTH-1:0]     axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
    logic [DATA_WIDTH-1:0]   wdata, wdata_nxt, rdata_nxt;
    logic [DATA_WIDTH/8-1:0] strb, strb_nxt;
    logic                    is_wr, is_wr_nxt;
    logic                    aw_v, aw_v_nxt, w_v, w_v_nxt, ar_v, ar_v_nxt;
    logic                    rdv_nxt, wrv_nxt, expired;
    logic [1:0]              resp_nxt;
    logic [TW-1:0]           tcnt, tcnt_nxt;
    logic                    unused_burstcount;

    assign unused_burstcount = avs_burstcount;

    // expiry lands on the last waiting cycle so the error strobe is registered at that edge
    assign expired = (TIMEOUT_CYCLES > 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    assign avs_waitrequest = (state != IDLE);
    assign axi_awaddr      = addr;
    assign axi_araddr      = addr;
    assign axi_awprot      = PROT_DEFAULT;
    assign axi_arprot      = PROT_DEFAULT;
    assign axi_awvalid     = aw_v;
    assign axi_wvalid      = w_v;
    assign axi_arvalid     = ar_v;
    assign axi_wdata       = wdata;
    assign axi_wstrb       = strb;
    assign axi_bready      = (state == WR_RESP) || (state == DRAIN && is_wr);
    assign axi_rready      = (state == RD_RESP) || (state == DRAIN && !is_wr);

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        strb_nxt  = strb;
        is_wr_nxt = is_wr;
        aw_v_nxt  = aw_v;
        w_v_nxt   = w_v;
        ar_v_nxt  = ar_v;
        tcnt_nxt  = tcnt;
        rdata_nxt = avs_readdata;
        resp_nxt  = avs_response;
        rdv_nxt   = 1'b0;
        wrv_nxt   = 1'b0;
        case (state)
            IDLE: if (avs_write || avs_read) begin
                addr_nxt  = avs_address;
                wdata_nxt = avs_writedata;
                strb_nxt  = avs_byteenable;
                is_wr_nxt = avs_write;
                aw_v_nxt  = avs_write;
                w_v_nxt   = avs_write;
                ar_v_nxt  = !avs_write;
                state_nxt = avs_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                aw_v_nxt = aw_v && !axi_awready;
                w_v_nxt  = w_v && !axi_wready;
                if (!aw_v_nxt && !w_v_nxt) begin
                    state_nxt = WR_RESP;
                    tcnt_nxt  = '0;
                end
            end
            RD_REQ: if (axi_arready) begin
                ar_v_nxt  = 1'b0;
                state_nxt = RD_RESP;
                tcnt_nxt  = '0;
            end
            WR_RESP: begin
                tcnt_nxt = tcnt + TW'(1);
                if (axi_bvalid || expired) begin
                    wrv_nxt   = 1'b1;
                    resp_nxt  = axi_bvalid ? axi_bresp : RESP_DECERR;
                    state_nxt = axi_bvalid ? IDLE : DRAIN;
                end
            end
            RD_RESP: begin
                tcnt_nxt = tcnt + TW'(1);
                if (axi_rvalid || expired) begin
                    rdv_nxt   = 1'b1;
                    rdata_nxt = axi_rvalid ? axi_rdata : '0;
                    resp_nxt  = axi_rvalid ? axi_rresp : RESP_DECERR;
                    state_nxt = axi_rvalid ? IDLE : DRAIN;
                end
            end
            DRAIN: if (is_wr ? axi_bvalid : axi_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state                  <= IDLE;
            addr                   <= '0;
            wdata                  <= '0;
            strb                   <= '0;
            is_wr                  <= 1'b0;
            aw_v                   <= 1'b0;
            w_v                    <= 1'b0;
            ar_v                   <= 1'b0;
            tcnt                   <= '0;
            avs_readdata           <= '0;
            avs_response           <= RESP_OKAY;
            avs_readdatavalid      <= 1'b0;
            avs_writeresponsevalid <= 1'b0;
        end else begin
            state                  <= state_nxt;
            addr                   <= addr_nxt;
            wdata                  <= wdata_nxt;
            strb                   <= strb_nxt;
            is_wr                  <= is_wr_nxt;
            aw_v                   <= aw_v_nxt;
            w_v                    <= w_v_nxt;
            ar_v                   <= ar_v_nxt;
            tcnt                   <= tcnt_nxt;
            avs_readdata           <= rdata_nxt;
            avs_response           <= resp_nxt;
            avs_readdatavalid      <= rdv_nxt;
            avs_writeresponsevalid <= wrv_nxt;
        end
    end

    always @(posedge i_clk)
        if (i_rstn && state == IDLE)
            assert (!(avs_read && avs_write))
            else $warning("avmm2axi4lite_bridge: avs_read and avs_write both high, read dropped");

endmodule

// File: tb/tb_avmm2axi4lite_bridge.sv
// tb_avmm2axi4lite_bridge: randomized bench with a memory-backed AXI4-Lite target and a timing/response model
module tb_avmm2axi4lite_bridge;

    localparam int TO = 16;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [31:0] avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic        avs_burstcount = 1'b1;
    logic        avs_waitrequest, avs_readdatavalid, avs_writeresponsevalid;
    logic [31:0] avs_readdata;
    logic [1:0]  avs_response;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [1:0]  axi_bresp, axi_rresp;

    always #5 i_clk = ~i_clk;

    avmm2axi4lite_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable), .avs_burstcount(avs_burstcount),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .avs_writeresponsevalid(avs_writeresponsevalid), .avs_response(avs_response),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // AXI4-Lite target: per-transaction delays, 16-word memory, handshake counters
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  t_resp = '0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
    logic        aw_done = 1'b0, w_done = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [31:0] cap_a = '0, cap_d = '0, last_a = '0, last_d = '0;
    logic [3:0]  cap_s = '0, last_s = '0, r_idx = '0;
    logic [31:0] tmem [16] = '{default: '0};
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [31:0] cur_a, cur_d;
    logic [3:0]  cur_s;

    assign axi_awready = axi_awvalid && aw_wait >= aw_dly;
    assign axi_wready  = axi_wvalid && w_wait >= w_dly;
    assign axi_arready = axi_arvalid && ar_wait >= ar_dly;
    assign axi_bvalid  = b_pend && b_wait >= b_dly;
    assign axi_rvalid  = r_pend && r_wait >= r_dly;
    assign axi_bresp   = t_resp;
    assign axi_rresp   = t_resp;
    assign axi_rdata   = tmem[r_idx];
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;
    assign b_hs  = axi_bvalid && axi_bready;
    assign r_hs  = axi_rvalid && axi_rready;
    assign cur_a = aw_hs ? axi_awaddr : cap_a;
    assign cur_d = w_hs ? axi_wdata : cap_d;
    assign cur_s = w_hs ? axi_wstrb : cap_s;

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
        end else begin
            aw_wait <= (aw_hs || !axi_awvalid) ? 0 : aw_wait + 1;
            w_wait  <= (w_hs || !axi_wvalid) ? 0 : w_wait + 1;
            ar_wait <= (ar_hs || !axi_arvalid) ? 0 : ar_wait + 1;
            b_wait  <= b_wait + 1;
            r_wait  <= r_wait + 1;
            if (aw_hs) begin cap_a <= axi_awaddr; n_aw <= n_aw + 1; end
            if (w_hs) begin cap_d <= axi_wdata; cap_s <= axi_wstrb; n_w <= n_w + 1; end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b1; b_wait <= 0;
                last_a <= cur_a; last_d <= cur_d; last_s <= cur_s;
                for (int k = 0; k < 4; k++)
                    if (cur_s[k]) tmem[cur_a[5:2]][k*8 +: 8] <= cur_d[k*8 +: 8];
            end else begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
            end
            if (b_hs) begin b_pend <= 1'b0; n_b <= n_b + 1; end
            if (ar_hs) begin r_pend <= 1'b1; r_wait <= 0; r_idx <= axi_araddr[5:2]; n_ar <= n_ar + 1; end
            if (r_hs) begin r_pend <= 1'b0; n_r <= n_r + 1; end
        end
    end

    // AVMM-side strobe monitor
    int          cyc = 0, n_wrv = 0, n_rdv = 0, wrv_cyc = 0, rdv_cyc = 0;
    logic [1:0]  wrv_resp = '0, rdv_resp = '0;
    logic [31:0] rdv_data = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (avs_writeresponsevalid) begin n_wrv <= n_wrv + 1; wrv_cyc <= cyc; wrv_resp <= avs_response; end
        if (avs_readdatavalid) begin n_rdv <= n_rdv + 1; rdv_cyc <= cyc; rdv_data <= avs_readdata; rdv_resp <= avs_response; end
    end

    // reference memory as seen from the AVMM side
    logic [31:0] ref_mem [16] = '{default: '0};

    // da: AW (or AR) delay, dw: W delay, dr: B/R delay after the request phase
    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input int da, input int dw, input int dr, input logic [1:0] resp);
        int c0, rel, req, lat;
        bit to;
        logic [3:0] idx;
        logic [31:0] exp_rd;
        int na, nw, nar, nb, nr, nwv, nrv;
        na = n_aw; nw = n_w; nar = n_ar; nb = n_b; nr = n_r; nwv = n_wrv; nrv = n_rdv;
        idx = addr[5:2];
        req = wr ? ((da > dw) ? da : dw) : da;
        to = (dr >= TO);
        lat = 2 + req + (to ? TO - 1 : dr);
        if (wr)
            for (int k = 0; k < 4; k++)
                if (be[k]) ref_mem[idx][k*8 +: 8] = data[k*8 +: 8];
        exp_rd = to ? 32'h0 : ref_mem[idx];
        aw_dly = da; ar_dly = da; w_dly = dw; b_dly = dr; r_dly = dr; t_resp = resp;
        @(negedge i_clk);
        chk("idle_before_cmd", avs_waitrequest, 0);
        avs_write = wr; avs_read = rd; avs_address = addr; avs_writedata = data; avs_byteenable = be;
        @(negedge i_clk);
        c0 = cyc;
        avs_write = 1'b0; avs_read = 1'b0;
        chk("waitreq_busy", avs_waitrequest, 1);
        if (wr) begin
            chk("awvalid_rise", axi_awvalid, 1);
            chk("wvalid_rise", axi_wvalid, 1);
            chk("awprot", axi_awprot, 0);
            chk("no_arvalid", axi_arvalid, 0);
        end else begin
            chk("arvalid_rise", axi_arvalid, 1);
            chk("araddr", axi_araddr, addr);
            chk("arprot", axi_arprot, 0);
            chk("no_awvalid", axi_awvalid, 0);
        end
        @(negedge i_clk);
        if (wr) begin
            chk("awvalid_hold", axi_awvalid, da >= 1);
            chk("wvalid_hold", axi_wvalid, dw >= 1);
        end else
            chk("arvalid_hold", axi_arvalid, da >= 1);
        for (int i = 0; i < 100 && avs_waitrequest; i++) @(negedge i_clk);
        rel = cyc - c0;
        chk("waitreq_release", rel, 2 + req + dr);
        repeat (2) @(negedge i_clk);
        if (wr) begin
            chk("wrv_count", n_wrv - nwv, 1);
            chk("rdv_count", n_rdv - nrv, 0);
            chk("wrv_latency", wrv_cyc - c0, lat);
            chk("wr_response", wrv_resp, to ? 2'b11 : resp);
            chk("aw_count", n_aw - na, 1);
            chk("w_count", n_w - nw, 1);
            chk("b_count", n_b - nb, 1);
            chk("ar_count", n_ar - nar, 0);
            chk("awaddr", last_a, addr);
            chk("wdata", last_d, data);
            chk("wstrb", last_s, be);
        end else begin
            chk("rdv_count", n_rdv - nrv, 1);
            chk("wrv_count", n_wrv - nwv, 0);
            chk("rdv_latency", rdv_cyc - c0, lat);
            chk("rd_response", rdv_resp, to ? 2'b11 : resp);
            chk("readdata", rdv_data, exp_rd);
            chk("ar_count", n_ar - nar, 1);
            chk("r_count", n_r - nr, 1);
            chk("aw_count", n_aw - na, 0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_waitreq"}, avs_waitrequest, 0);
        chk({tag, "_rdv"}, avs_readdatavalid, 0);
        chk({tag, "_wrv"}, avs_writeresponsevalid, 0);
        chk({tag, "_readdata"}, avs_readdata, 0);
        chk({tag, "_response"}, avs_response, 0);
        chk({tag, "_valids"}, {axi_awvalid, axi_wvalid, axi_arvalid}, 0);
        chk({tag, "_readys"}, {axi_bready, axi_rready}, 0);
    endtask

    bit          w;
    int          da, dw, dr;
    logic [31:0] ra;

    initial begin
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("in_reset");
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk_reset_outputs("after_reset");

        txn(1, 0, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00);
        txn(1, 0, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b00);
        txn(0, 1, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 5, 2'b10);

        // reset while waiting for B; AW/W already landed in the target
        aw_dly = 0; w_dly = 0; b_dly = 10; t_resp = 2'b00;
        @(negedge i_clk);
        avs_write = 1'b1; avs_address = 32'h0000_0304; avs_writedata = 32'h0BAD_0BAD; avs_byteenable = 4'hF;
        @(negedge i_clk);
        avs_write = 1'b0;
        for (int i = 0; i < 20 && !axi_bready; i++) @(negedge i_clk);
        chk("bready_before_reset", axi_bready, 1);
        ref_mem[1] = 32'h0BAD_0BAD;
        i_rstn = 1'b0;
        #1;
        chk_reset_outputs("mid_wresp");
        @(negedge i_clk);
        i_rstn = 1'b1;
        txn(1, 0, 32'h0000_0108, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b00);
        txn(0, 1, 32'h0000_0304, 32'h0, 4'h0, 1, 0, 0, 2'b00);

        txn(1, 0, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 0, 4, 0, 2'b00);
        txn(0, 1, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 39, 2'b00);
        txn(0, 1, 32'h0000_0104, 32'h0, 4'h0, 0, 0, TO - 1, 2'b01);
        txn(0, 1, 32'h0000_0104, 32'h0, 4'h0, 0, 0, TO, 2'b00);
        txn(1, 0, 32'h0000_0110, 32'h0F0F_0F0F, 4'hF, 2, 1, TO, 2'b00);
        txn(1, 0, 32'h0000_0114, 32'hF0F0_F0F0, 4'hF, 1, 2, TO - 1, 2'b10);
        txn(1, 1, 32'h0000_0118, 32'h7777_8888, 4'hF, 0, 0, 0, 2'b00);
        txn(1, 0, 32'h0000_0104, 32'h1122_3344, 4'b0101, 0, 0, 2, 2'b00);
        txn(0, 1, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, 2'b00);

        for (int t = 0; t < 40; t++) begin
            w  = 1'($urandom_range(0, 1));
            da = $urandom_range(0, 4);
            dw = $urandom_range(0, 4);
            dr = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 5);
            ra = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
            txn(w, !w, ra, $urandom(), 4'($urandom_range(0, 15)), da, dw, dr, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
